// File: rtl/norz_seq_pkg.sv
// Shared definitions for the I-table fetch sequencer: FSM states, prefix
// byte values, the ITABLE clear value and the opcode bit that carries the
// IX/IY selection into the prefixed decode table.
package norz_seq_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    OPND_LO = 3'd2,
    OPND_HI = 3'd3,
    WRBK    = 3'd4
  } seq_state_t;

  localparam logic [7:0] PFX_IX_BYTE    = 8'hDD;
  localparam logic [7:0] PFX_IY_BYTE    = 8'hFD;
  localparam logic [7:0] ITABLE_RESET   = 8'h00;
  localparam int         ITABLE_PFX_BIT = 2;

  // Decoder response as captured during the DECODE cycle.
  typedef struct packed {
    logic wr_ix;
    logic wr_iy;
    logic set_cm1;
    logic reset_itable;
    logic ophd;
  } dec_rsp_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PFX_IX_BYTE) || (b == PFX_IY_BYTE);
  endfunction

  // Folds the active index prefix into the opcode (0 = IX, 1 = IY).
  function automatic logic [7:0] apply_prefix(input logic [7:0] op, input logic pfx_iy);
    logic [7:0] r;
    r = op;
    r[ITABLE_PFX_BIT] = pfx_iy;
    return r;
  endfunction

endpackage

// File: rtl/itable_operand_latch.sv
// Operand assembly for the fetch sequencer: captures the low operand byte,
// forms the {hi, lo} write-back word when the high byte arrives, and holds
// the IX/IY destination chosen by the decoder until the write-back.
module itable_operand_latch
  import norz_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        notRESET,
  input  logic [7:0]  byte_in,
  input  logic        lo_load,
  input  logic        hi_load,
  input  logic        dest_load,
  input  logic        dest_sel,
  output logic        dest_iy,
  output logic [15:0] wdata
);

  logic [7:0] lo_byte;

  // Operand bytes and destination; wdata only changes on a high-byte load so it holds between write-backs.
  always_ff @(posedge CLK) begin
    if (!notRESET) begin
      lo_byte <= 8'h00;
      wdata   <= 16'h0000;
      dest_iy <= 1'b0;
    end else begin
      if (lo_load) begin
        lo_byte <= byte_in;
      end
      if (hi_load) begin
        wdata <= {byte_in, lo_byte};
      end
      if (dest_load) begin
        dest_iy <= dest_sel;
      end
    end
  end

endmodule

// File: rtl/itable_fetch_sequencer.sv
// Producer side of the I-table decoder interface. Collects DD/FD prefixes
// and the opcode, loads ITABLE/notITABLE, pulses I_enable, then follows the
// decoder's response through operand fetch and IX/IY write-back.
// Build option: define NORZ_PREFIX_CHAIN_EN to accept consecutive prefixes
// (last one wins); otherwise a second prefix is flagged illegal.
module itable_fetch_sequencer
  import norz_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        notRESET,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        M1,
  output logic [7:0]  ITABLE,
  output logic [7:0]  notITABLE,
  output logic        I_enable,
  input  logic        PR_Write_IX_high,
  input  logic        PR_Write_IY_high,
  input  logic        P2_Set_CM1,
  input  logic        P2_Reset_ITABLE,
  input  logic        Pa_Ophd,
  output logic        ix_we,
  output logic        iy_we,
  output logic [15:0] wdata,
  output logic        illegal
);

  seq_state_t state;
  dec_rsp_t   rsp;
  logic       pfx_v;
  logic       pfx_iy;
  logic       dest_iy;
  logic       xfer;
  logic       dec_abort;
  logic [7:0] pfx_opcode;

  // byte_ready is registered alongside state, so it already reflects the current state.
  assign xfer       = byte_valid & byte_ready;
  assign pfx_opcode = apply_prefix(byte_in, pfx_iy);
  assign dec_abort  = (PR_Write_IX_high == PR_Write_IY_high) | ~Pa_Ophd;

  itable_operand_latch u_latch (
    .CLK       (CLK),
    .notRESET  (notRESET),
    .byte_in   (byte_in),
    .lo_load   ((state == OPND_LO) & xfer),
    .hi_load   ((state == OPND_HI) & xfer),
    .dest_load (state == DECODE),
    .dest_sel  (PR_Write_IY_high),
    .dest_iy   (dest_iy),
    .wdata     (wdata)
  );

  // Sequencer FSM with all handshake, decode and strobe outputs registered.
  always_ff @(posedge CLK) begin
    if (!notRESET) begin
      state      <= FETCH;
      rsp        <= '0;
      pfx_v      <= 1'b0;
      pfx_iy     <= 1'b0;
      ITABLE     <= ITABLE_RESET;
      notITABLE  <= ~ITABLE_RESET;
      byte_ready <= 1'b1;
      M1         <= 1'b1;
      I_enable   <= 1'b0;
      ix_we      <= 1'b0;
      iy_we      <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      I_enable <= 1'b0;
      ix_we    <= 1'b0;
      iy_we    <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        FETCH: begin
          if (xfer) begin
            if (is_prefix(byte_in)) begin
`ifdef NORZ_PREFIX_CHAIN_EN
              pfx_iy <= (byte_in == PFX_IY_BYTE);
              pfx_v  <= 1'b1;
`else
              if (pfx_v) begin
                illegal <= 1'b1;
                pfx_v   <= 1'b0;
              end else begin
                pfx_iy <= (byte_in == PFX_IY_BYTE);
                pfx_v  <= 1'b1;
              end
`endif
            end else if (pfx_v) begin
              ITABLE     <= pfx_opcode;
              notITABLE  <= ~pfx_opcode;
              state      <= DECODE;
              byte_ready <= 1'b0;
              M1         <= 1'b0;
              I_enable   <= 1'b1;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        DECODE: begin
          rsp <= '{wr_ix:        PR_Write_IX_high,
                   wr_iy:        PR_Write_IY_high,
                   set_cm1:      P2_Set_CM1,
                   reset_itable: P2_Reset_ITABLE,
                   ophd:         Pa_Ophd};
          if (dec_abort) begin
            illegal    <= 1'b1;
            state      <= FETCH;
            byte_ready <= 1'b1;
            M1         <= 1'b1;
            if (P2_Reset_ITABLE) begin
              ITABLE    <= ITABLE_RESET;
              notITABLE <= ~ITABLE_RESET;
              pfx_v     <= 1'b0;
            end
          end else begin
            state      <= OPND_LO;
            byte_ready <= 1'b1;
            M1         <= 1'b0;
          end
        end
        OPND_LO: begin
          if (xfer) begin
            state <= OPND_HI;
          end
        end
        OPND_HI: begin
          if (xfer) begin
            state      <= WRBK;
            byte_ready <= 1'b0;
            ix_we      <= rsp.ophd & rsp.wr_ix & ~dest_iy;
            iy_we      <= rsp.ophd & rsp.wr_iy & dest_iy;
          end
        end
        WRBK: begin
          state      <= FETCH;
          byte_ready <= 1'b1;
          M1         <= 1'b1;
          illegal    <= ~rsp.set_cm1;
          if (rsp.reset_itable) begin
            ITABLE    <= ITABLE_RESET;
            notITABLE <= ~ITABLE_RESET;
            pfx_v     <= 1'b0;
          end
        end
        default: begin
          state      <= FETCH;
          byte_ready <= 1'b1;
          M1         <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itable_fetch_sequencer.sv
// Self-checking bench for itable_fetch_sequencer. A per-instruction model
// predicts the byte stream consumed, the ITABLE value seen at each decode
// and the ordered list of write/illegal events; the DUT's observed events
// are compared against it. Honours NORZ_PREFIX_CHAIN_EN like the design.
module tb_itable_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        notRESET;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        M1;
  logic [7:0]  ITABLE;
  logic [7:0]  notITABLE;
  logic        I_enable;
  logic        PR_Write_IX_high;
  logic        PR_Write_IY_high;
  logic        P2_Set_CM1;
  logic        P2_Reset_ITABLE;
  logic        Pa_Ophd;
  logic        ix_we;
  logic        iy_we;
  logic [15:0] wdata;
  logic        illegal;

  always #5 CLK = ~CLK;

  itable_fetch_sequencer dut (
    .CLK              (CLK),
    .notRESET         (notRESET),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .M1               (M1),
    .ITABLE           (ITABLE),
    .notITABLE        (notITABLE),
    .I_enable         (I_enable),
    .PR_Write_IX_high (PR_Write_IX_high),
    .PR_Write_IY_high (PR_Write_IY_high),
    .P2_Set_CM1       (P2_Set_CM1),
    .P2_Reset_ITABLE  (P2_Reset_ITABLE),
    .Pa_Ophd          (Pa_Ophd),
    .ix_we            (ix_we),
    .iy_we            (iy_we),
    .wdata            (wdata),
    .illegal          (illegal)
  );

  // Response bits: {wr_ix, wr_iy, set_cm1, reset_itable, ophd}
  localparam logic [4:0] R_IX   = 5'b10000;
  localparam logic [4:0] R_IY   = 5'b01000;
  localparam logic [4:0] R_CM1  = 5'b00100;
  localparam logic [4:0] R_RST  = 5'b00010;
  localparam logic [4:0] R_OPHD = 5'b00001;

  localparam logic [3:0] EV_ILL = 4'd1;
  localparam logic [3:0] EV_IX  = 4'd2;
  localparam logic [3:0] EV_IY  = 4'd3;

  int total_checks = 0;
  int bad_checks   = 0;

  logic [7:0]  byte_q[$];
  logic [4:0]  rsp_q[$];
  logic [7:0]  exp_itable[$];
  logic [19:0] exp_ev[$];
  logic [19:0] obs_ev[$];
  int          exp_decodes;
  int          obs_decodes;
  int          valid_mode;
  logic        prev_ready;

  logic        m_pfx_v;
  logic        m_pfx_iy;
  logic [7:0]  m_itable;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_checks++;
    if (got !== want) begin
      bad_checks++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    m_pfx_v  = 1'b0;
    m_pfx_iy = 1'b0;
    m_itable = 8'h00;
    byte_q.delete();
    rsp_q.delete();
    exp_itable.delete();
    exp_ev.delete();
    exp_decodes = 0;
  endtask

  // Queue one instruction and predict its effect from the sequencing rules.
  task automatic addInstr(input int npfx, input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] op, input logic [4:0] rsp,
                          input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] pb;
    logic       single_dest;
    for (int i = 0; i < npfx; i++) begin
      pb = (i == 0) ? p0 : p1;
      byte_q.push_back(pb);
      if (!m_pfx_v) begin
        m_pfx_v  = 1'b1;
        m_pfx_iy = (pb == 8'hFD);
      end else begin
`ifdef NORZ_PREFIX_CHAIN_EN
        m_pfx_iy = (pb == 8'hFD);
`else
        exp_ev.push_back({EV_ILL, 16'h0000});
        m_pfx_v = 1'b0;
`endif
      end
    end
    byte_q.push_back(op);
    if (!m_pfx_v) begin
      exp_ev.push_back({EV_ILL, 16'h0000});
      return;
    end
    m_itable = (op & 8'hFB) | (m_pfx_iy ? 8'h04 : 8'h00);
    exp_itable.push_back(m_itable);
    exp_decodes++;
    rsp_q.push_back(rsp);
    single_dest = (rsp[4] != rsp[3]);
    if (!single_dest || !rsp[0]) begin
      exp_ev.push_back({EV_ILL, 16'h0000});
    end else begin
      byte_q.push_back(lo);
      byte_q.push_back(hi);
      exp_ev.push_back({(rsp[3] ? EV_IY : EV_IX), hi, lo});
      if (!rsp[2]) exp_ev.push_back({EV_ILL, 16'h0000});
    end
    if (rsp[1]) begin
      m_itable = 8'h00;
      m_pfx_v  = 1'b0;
    end
  endtask

  // One clock: retire a consumed byte, record DUT events, drive next inputs.
  task automatic cycleStep();
    logic [7:0] want_it;
    logic [4:0] r;
    @(posedge CLK);
    #1;
    if (byte_valid && prev_ready && byte_q.size() != 0) void'(byte_q.pop_front());
    if (I_enable) begin
      obs_decodes++;
      if (exp_itable.size() != 0) begin
        want_it = exp_itable.pop_front();
        checkOutput("itable_at_decode", {24'h0, ITABLE}, {24'h0, want_it});
        checkOutput("notitable_at_decode", {24'h0, notITABLE}, {24'h0, ~want_it});
      end
    end
    if (ix_we || iy_we || illegal)
      checkOutput("strobe_exclusive", $countones({ix_we, iy_we, illegal}), 1);
    if (illegal) obs_ev.push_back({EV_ILL, 16'h0000});
    if (ix_we)   obs_ev.push_back({EV_IX, wdata});
    if (iy_we)   obs_ev.push_back({EV_IY, wdata});
    prev_ready = byte_ready;
    if (byte_q.size() != 0) begin
      byte_in = byte_q[0];
      case (valid_mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = ~byte_valid;
        default: byte_valid = ($urandom_range(0, 2) != 0);
      endcase
    end else begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
    end
    if (I_enable && rsp_q.size() != 0) r = rsp_q.pop_front();
    else r = 5'($urandom);
    {PR_Write_IX_high, PR_Write_IY_high, P2_Set_CM1, P2_Reset_ITABLE, Pa_Ophd} = r;
  endtask

  task automatic applyStimulus(input string name, input int mode);
    int budget;
    int idle;
    valid_mode  = mode;
    obs_ev.delete();
    obs_decodes = 0;
    budget      = 0;
    idle        = 0;
    while ((byte_q.size() != 0 || idle < 8) && budget < 5000) begin
      cycleStep();
      budget++;
      if (byte_q.size() == 0) idle++;
      else idle = 0;
    end
    checkOutput({name, "_in_budget"}, (budget < 5000), 1);
    checkOutput({name, "_decodes"}, obs_decodes, exp_decodes);
    checkOutput({name, "_rsp_left"}, rsp_q.size(), 0);
    checkOutput({name, "_event_count"}, obs_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size(); i++) begin
      if (i < obs_ev.size())
        checkOutput($sformatf("%s_event%0d", name, i), {12'h0, obs_ev[i]}, {12'h0, exp_ev[i]});
    end
    exp_ev.delete();
    exp_itable.delete();
    exp_decodes = 0;
  endtask

  task automatic applyReset();
    notRESET   = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    notRESET   = 1'b1;
    prev_ready = byte_ready;
    modelReset();
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_itable"},     {24'h0, ITABLE},    32'h00);
    checkOutput({name, "_notitable"},  {24'h0, notITABLE}, 32'hFF);
    checkOutput({name, "_byte_ready"}, byte_ready, 1);
    checkOutput({name, "_m1"},         M1, 1);
    checkOutput({name, "_i_enable"},   I_enable, 0);
    checkOutput({name, "_ix_we"},      ix_we, 0);
    checkOutput({name, "_iy_we"},      iy_we, 0);
    checkOutput({name, "_illegal"},    illegal, 0);
    checkOutput({name, "_wdata"},      {16'h0, wdata}, 32'h0000);
  endtask

  task automatic addRandomInstr();
    int         npfx;
    int         d;
    logic [7:0] op;
    logic [4:0] rsp;
    npfx = ($urandom_range(0, 9) == 0) ? 0 : (($urandom_range(0, 9) < 7) ? 1 : 2);
    do op = 8'($urandom); while (op == 8'hDD || op == 8'hFD);
    d   = $urandom_range(0, 9);
    rsp = (d < 4) ? R_IX : ((d < 8) ? R_IY : (R_IX | R_IY));
    if ($urandom_range(0, 9) < 8) rsp = rsp | R_OPHD;
    if ($urandom_range(0, 9) < 8) rsp = rsp | R_CM1;
    if ($urandom_range(0, 9) < 7) rsp = rsp | R_RST;
    addInstr(npfx, ($urandom_range(0, 1) != 0) ? 8'hDD : 8'hFD,
             ($urandom_range(0, 1) != 0) ? 8'hDD : 8'hFD,
             op, rsp, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    notRESET   = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    {PR_Write_IX_high, PR_Write_IY_high, P2_Set_CM1, P2_Reset_ITABLE, Pa_Ophd} = 5'b0;
    valid_mode = 0;
    prev_ready = 1'b0;
    modelReset();

    applyReset();
    checkResetValues("reset0");

    addInstr(1, 8'hDD, 8'h00, 8'h21, R_IX | R_OPHD | R_CM1 | R_RST, 8'h34, 8'h12);
    applyStimulus("ix_basic", 0);
    checkOutput("ix_basic_itable_after", {24'h0, ITABLE}, 32'h00);
    checkOutput("ix_basic_notitable_after", {24'h0, notITABLE}, 32'hFF);
    checkOutput("ix_basic_m1_after", M1, 1);

    addInstr(1, 8'hFD, 8'h00, 8'h21, R_IY | R_OPHD | R_CM1 | R_RST, 8'hCD, 8'hAB);
    applyStimulus("iy_toggle", 1);

    byte_q.push_back(8'hDD);
    byte_q.push_back(8'h21);
    byte_q.push_back(8'h34);
    rsp_q.push_back(R_IX | R_OPHD | R_CM1 | R_RST);
    exp_itable.push_back(8'h21);
    exp_decodes = 1;
    applyStimulus("partial_operand", 0);
    applyReset();
    checkResetValues("reset_mid");
    addInstr(1, 8'hDD, 8'h00, 8'h21, R_IX | R_OPHD | R_CM1 | R_RST, 8'h78, 8'h56);
    applyStimulus("after_reset", 0);

    addInstr(2, 8'hDD, 8'hFD, 8'h21, R_IY | R_OPHD | R_CM1 | R_RST, 8'h01, 8'h00);
    applyStimulus("prefix_chain", 0);

    addInstr(0, 8'h00, 8'h00, 8'h21, R_IX | R_OPHD | R_CM1 | R_RST, 8'h00, 8'h00);
    applyStimulus("unprefixed", 0);

    addInstr(1, 8'hDD, 8'h00, 8'h21, R_IX | R_IY | R_OPHD | R_CM1 | R_RST, 8'h00, 8'h00);
    applyStimulus("both_dest", 2);
    checkOutput("both_dest_m1", M1, 1);
    checkOutput("both_dest_ready", byte_ready, 1);

    applyReset();
    for (int i = 0; i < 60; i++) addRandomInstr();
    applyStimulus("random_a", 2);
    for (int i = 0; i < 40; i++) addRandomInstr();
    applyStimulus("random_b", 1);
    checkOutput("final_itable", {24'h0, ITABLE}, {24'h0, m_itable});
    checkOutput("final_notitable", {24'h0, notITABLE}, {24'h0, ~m_itable});

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
